instr_sequencer: RTL and testbench

- Instruction-cycle state machine that generates the 3-bit `state` and 4-bit `opcode` consumed by control_matrix.
- Fetches an instruction word from memory with a ready handshake and latches it into an instruction register.
- Steps DECODE, EXECUTE and WRITEBACK per opcode class, and halts on the HALT opcode.
- Honours the matrix's synchronous `state_machine_reset` restart request.

---
 rtl/seq_pkg.sv | 30 +++
 rtl/instr_sequencer_if.sv | 22 ++
 rtl/instr_reg.sv | 42 ++++
 rtl/instr_sequencer.sv | 109 ++++++++++
 tb/tb_instr_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer and control_matrix.
// Field helpers take a zero-extended word plus the MSB index so any INSTR_W <= 32 works.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd7
  } state_t;

  localparam logic [3:0] OP_ALU  = 4'b0001;
  localparam logic [3:0] OP_LOAD = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] HALT_OP_DEF = OP_HALT;

  function automatic logic [3:0] op_field(input logic [31:0] word, input logic [4:0] msb);
    return word[msb -: 4];
  endfunction

  // Everything below the 4-bit opcode belongs to the operand.
  function automatic logic [31:0] operand_field(input logic [31:0] word, input logic [4:0] msb);
    logic [31:0] mask;
    mask = (32'd1 << (msb - 5'd3)) - 32'd1;
    return word & mask;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction memory bus: the sequencer is the master, memory the slave.
interface instr_sequencer_if #(
  parameter int INSTR_W = 16
);

  logic [INSTR_W-1:0] instr_data;
  logic               mem_ready;
  logic               mem_req;

  modport master (
    output mem_req,
    input  instr_data,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    output instr_data,
    output mem_ready
  );

endinterface

// File: rtl/instr_reg.sv
// Instruction register: splits the fetched word into opcode and operand.
module instr_reg
  import seq_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic               clock,
  input  logic               state_reset_n,
  input  logic               load,
  input  logic [INSTR_W-1:0] data,
  output logic [3:0]         opcode,
  output logic [INSTR_W-5:0] operand
);

  logic [3:0]         opcode_q, opcode_d;
  logic [INSTR_W-5:0] operand_q, operand_d;
  logic [31:0]        word_ext;

  always_comb begin
    word_ext  = 32'(data);
    opcode_d  = opcode_q;
    operand_d = operand_q;
    if (load) begin
      opcode_d  = op_field(word_ext, 5'(INSTR_W - 1));
      operand_d = (INSTR_W - 4)'(operand_field(word_ext, 5'(INSTR_W - 1)));
    end
  end

  always_ff @(posedge clock or negedge state_reset_n) begin
    if (!state_reset_n) begin
      opcode_q  <= '0;
      operand_q <= '0;
    end else begin
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
    end
  end

  assign opcode  = opcode_q;
  assign operand = operand_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer feeding state and opcode to control_matrix.
// Owns the cycle FSM and the retired-instruction counter.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int          INSTR_W  = 16,
  parameter logic [15:0] WB_MASK  = 16'h00FF,
  parameter logic [15:0] MEM_MASK = 16'h0060,
  parameter logic [3:0]  HALT_OP  = HALT_OP_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic                clock,
  input  logic                state_reset_n,
  instr_sequencer_if.master   mem,
  input  logic                state_machine_reset,
  input  logic                resume,
  output logic [2:0]          state,
  output logic [3:0]          opcode,
  output logic [INSTR_W-5:0]  operand,
  output logic                ir_load,
  output logic                retire,
  output logic                halted,
  output logic [CNT_W-1:0]    instr_count
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               mem_req_int;
  logic               ir_load_int;
  logic               retire_int;
  logic               exec_done;

  instr_reg #(.INSTR_W(INSTR_W)) u_instr_reg (
    .clock         (clock),
    .state_reset_n (state_reset_n),
    .load          (ir_load_int),
    .data          (mem.instr_data),
    .opcode        (opcode),
    .operand       (operand)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_int = 1'b0;
    ir_load_int = 1'b0;
    retire_int  = 1'b0;
    exec_done   = !MEM_MASK[opcode] || mem.mem_ready;

    case (state_q)
      ST_FETCH: begin
        mem_req_int = 1'b1;
        if (mem.mem_ready) begin
          ir_load_int = 1'b1;
          state_d     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = (opcode == HALT_OP) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        mem_req_int = MEM_MASK[opcode];
        if (exec_done) begin
          if (WB_MASK[opcode]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d    = ST_FETCH;
            retire_int = 1'b1;
          end
        end
      end
      ST_WRITEBACK: begin
        retire_int = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        if (resume) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // The matrix restart wins over everything, including a load or a retire in flight.
    if (state_machine_reset) begin
      state_d     = ST_FETCH;
      ir_load_int = 1'b0;
      retire_int  = 1'b0;
    end

    count_d = retire_int ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clock or negedge state_reset_n) begin
    if (!state_reset_n) begin
      state_q <= ST_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Qualify with reset so an abandoned access drops mem_req while reset is still low.
  assign mem.mem_req  = mem_req_int & state_reset_n;
  assign ir_load      = ir_load_int & state_reset_n;
  assign retire       = retire_int & state_reset_n;
  assign halted       = (state_q == ST_HALT);
  assign state        = state_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: each driven cycle queues its expected outputs,
// a monitor pops and compares them mid-cycle. Counter is narrowed so the wrap is reachable.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int INSTR_W = 16;
  localparam int CNT_W   = 8;

  logic               clock = 1'b0;
  logic               state_reset_n;
  logic               state_machine_reset;
  logic               resume;
  logic [2:0]         state;
  logic [3:0]         opcode;
  logic [INSTR_W-5:0] operand;
  logic               ir_load;
  logic               retire;
  logic               halted;
  logic [CNT_W-1:0]   instr_count;

  instr_sequencer_if #(.INSTR_W(INSTR_W)) mem_if ();

  instr_sequencer #(
    .INSTR_W (INSTR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clock               (clock),
    .state_reset_n       (state_reset_n),
    .mem                 (mem_if),
    .state_machine_reset (state_machine_reset),
    .resume              (resume),
    .state               (state),
    .opcode              (opcode),
    .operand             (operand),
    .ir_load             (ir_load),
    .retire              (retire),
    .halted              (halted),
    .instr_count         (instr_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]         st;
    logic [3:0]         op;
    logic [INSTR_W-5:0] opnd;
    logic [CNT_W-1:0]   cnt;
    logic               req;
    logic               load;
    logic               ret;
    logic               halt;
  } exp_t;

  exp_t               sb[$];
  exp_t               mon_e;
  int                 checks = 0;
  int                 errors = 0;
  logic [3:0]         exp_op;
  logic [INSTR_W-5:0] exp_operand;
  logic [CNT_W-1:0]   exp_count;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be during that cycle.
  task automatic applyStimulus(input logic [15:0] data, input logic rdy, input logic smr,
                               input logic res, input logic [2:0] e_st, input logic e_req,
                               input logic e_load, input logic e_ret, input logic e_halt);
    exp_t e;
    @(negedge clock);
    mem_if.instr_data   = data;
    mem_if.mem_ready    = rdy;
    state_machine_reset = smr;
    resume              = res;
    e.st   = e_st;
    e.op   = exp_op;
    e.opnd = exp_operand;
    e.cnt  = exp_count;
    e.req  = e_req;
    e.load = e_load;
    e.ret  = e_ret;
    e.halt = e_halt;
    sb.push_back(e);
    if (e_load) begin
      exp_op      = data[15:12];
      exp_operand = data[11:0];
    end
    if (e_ret) exp_count = exp_count + 1'b1;
  endtask

  task automatic runInstr(input logic [15:0] word, input logic has_wb);
    applyStimulus(word, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(word, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(word, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, !has_wb, 1'b0);
    if (has_wb) applyStimulus(word, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge clock) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checkOutput("state",   32'(state),          32'(mon_e.st));
      checkOutput("opcode",  32'(opcode),         32'(mon_e.op));
      checkOutput("operand", 32'(operand),        32'(mon_e.opnd));
      checkOutput("count",   32'(instr_count),    32'(mon_e.cnt));
      checkOutput("mem_req", 32'(mem_if.mem_req), 32'(mon_e.req));
      checkOutput("ir_load", 32'(ir_load),        32'(mon_e.load));
      checkOutput("retire",  32'(retire),         32'(mon_e.ret));
      checkOutput("halted",  32'(halted),         32'(mon_e.halt));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    state_reset_n       = 1'b1;
    state_machine_reset = 1'b0;
    resume              = 1'b0;
    mem_if.instr_data   = 16'h1234;
    mem_if.mem_ready    = 1'b1;
    exp_op              = '0;
    exp_operand         = '0;
    exp_count           = '0;

    #1 state_reset_n = 1'b0;
    #2;
    checkOutput("rst_state",   32'(state),          32'd0);
    checkOutput("rst_opcode",  32'(opcode),         32'd0);
    checkOutput("rst_operand", 32'(operand),        32'd0);
    checkOutput("rst_count",   32'(instr_count),    32'd0);
    checkOutput("rst_ir_load", 32'(ir_load),        32'd0);
    checkOutput("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    checkOutput("rst_retire",  32'(retire),         32'd0);
    checkOutput("rst_halted",  32'(halted),         32'd0);
    mem_if.mem_ready = 1'b0;
    @(negedge clock);
    state_reset_n = 1'b1;

    // ALU opcode with writeback, memory always ready.
    runInstr({OP_ALU, 12'h234}, 1'b1);

    // Load opcode: fetch stalls three cycles, execute stalls two.
    for (int i = 0; i < 3; i++)
      applyStimulus({OP_LOAD, 12'hABC}, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus({OP_LOAD, 12'hABC}, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus({OP_LOAD, 12'hABC}, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      applyStimulus({OP_LOAD, 12'hABC}, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus({OP_LOAD, 12'hABC}, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus({OP_LOAD, 12'hABC}, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);

    // Opcode 9 has no writeback: retires in EXECUTE.
    runInstr(16'h9123, 1'b0);

    // HALT holds for ten cycles with memory ready, then resumes.
    applyStimulus({OP_HALT, 12'h000}, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus({OP_HALT, 12'h000}, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus({OP_HALT, 12'h000}, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus({OP_HALT, 12'h000}, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'h9123, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Restart request in EXECUTE suppresses retire; in FETCH it blocks the load.
    applyStimulus(16'h9AAA, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h9AAA, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h9AAA, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h5555, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h5555, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus({OP_HALT, 12'h000}, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus({OP_HALT, 12'h000}, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus({OP_HALT, 12'h000}, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus({OP_HALT, 12'h000}, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'h9001, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Run the counter up to all-ones, then one more retire wraps it.
    while (exp_count != '1) runInstr(16'h9001, 1'b0);
    runInstr(16'h9002, 1'b0);
    applyStimulus(16'h9002, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("count_wrap", 32'(exp_count), 32'd0);

    // Asynchronous reset dropped in the middle of a WRITEBACK cycle.
    applyStimulus({OP_ALU, 12'h777}, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus({OP_ALU, 12'h777}, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus({OP_ALU, 12'h777}, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    mem_if.mem_ready = 1'b1;
    #3;
    checkOutput("wb_state",  32'(state),  32'd3);
    checkOutput("wb_retire", 32'(retire), 32'd1);
    state_reset_n = 1'b0;
    #1;
    checkOutput("arst_state",   32'(state),          32'd0);
    checkOutput("arst_opcode",  32'(opcode),         32'd0);
    checkOutput("arst_operand", 32'(operand),        32'd0);
    checkOutput("arst_count",   32'(instr_count),    32'd0);
    checkOutput("arst_mem_req", 32'(mem_if.mem_req), 32'd0);
    checkOutput("arst_ir_load", 32'(ir_load),        32'd0);
    checkOutput("arst_retire",  32'(retire),         32'd0);
    checkOutput("arst_halted",  32'(halted),         32'd0);
    exp_op      = '0;
    exp_operand = '0;
    exp_count   = '0;
    @(negedge clock);
    mem_if.mem_ready = 1'b0;
    state_reset_n    = 1'b1;
    applyStimulus(16'h9003, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clock);
    #3;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
